mem_pipe_ctl: RTL and testbench

- Responder side of the load/store-queue pipe-request protocol.
- Arbitrates per-entry pipe requests from LDQ and STQ entries at mm0 and returns a one-hot grant in the same cycle.
- Carries the granted t_mempipe_arb packet down stages mm1..mm5 and issues the data-cache lookup at mm1.
- At mm5 broadcasts pipe_valid/pipe_req_pkt/pipe_action (complete or recycle), which every queue entry decodes by arb_type and id.

---
 rtl/mem_pipe_ctl_pkg.sv | 40 ++++
 rtl/mem_pipe_ctl_rr_arb.sv | 29 ++
 rtl/mem_pipe_ctl.sv | 130 +++++++++++++
 tb/tb_mem_pipe_ctl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pipe_ctl_pkg.sv
// Shared types for the memory pipe controller: arbitration packet, mm5 action,
// nuke packet, and queue/pipe sizing.
package mem_pipe_ctl_pkg;

    localparam int unsigned LDQ_NUM_ENTRIES    = 8;
    localparam int unsigned STQ_NUM_ENTRIES    = 8;
    localparam int unsigned NUM_MEMPIPE_STAGES = 5;
    localparam int unsigned ID_W               = 4;
    localparam int unsigned VADDR_W            = 32;

    typedef logic [VADDR_W-1:0] t_vaddr;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } t_mem_arb_type;

    typedef struct packed {
        t_mem_arb_type              arb_type;
        logic [ID_W-1:0]            id;
        t_vaddr                     addr;
        logic                       nukeable;
        logic [STQ_NUM_ENTRIES-1:0] older_stq_ents;
    } t_mempipe_arb;

    typedef struct packed {
        logic       complete;
        logic       recycle;
        logic [1:0] rsvd;
    } t_mempipe_action;

    typedef struct packed {
        logic valid;
    } t_nuke_pkt;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_pipe_ctl_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins, wrapping N-1 -> 0.
module rr_arb #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic        found;
        int unsigned j;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_pipe_ctl.sv
// Memory pipe controller: arbitrates LDQ/STQ pipe requests at mm0, carries the
// granted packet through mm1..mm5 and broadcasts complete/recycle at mm5.
module mem_pipe_ctl
    import mem_pipe_ctl_pkg::*;
#(
    parameter int unsigned NUM_LD = LDQ_NUM_ENTRIES,
    parameter int unsigned NUM_ST = STQ_NUM_ENTRIES
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [$bits(t_nuke_pkt)-1:0]               nuke_rb1,
    input  logic [NUM_LD-1:0]                          ld_req_mm0,
    input  logic [NUM_LD-1:0][$bits(t_mempipe_arb)-1:0] ld_req_pkt_mm0,
    output logic [NUM_LD-1:0]                          ld_gnt_mm0,
    input  logic [NUM_ST-1:0]                          st_req_mm0,
    input  logic [NUM_ST-1:0][$bits(t_mempipe_arb)-1:0] st_req_pkt_mm0,
    output logic [NUM_ST-1:0]                          st_gnt_mm0,
    input  logic [NUM_ST-1:0]                          stq_e_valid,
    output logic                                       dc_req_mm1,
    output logic [$bits(t_vaddr)-1:0]                  dc_addr_mm1,
    input  logic                                       dc_hit_mm5,
    output logic                                       pipe_valid_mm5,
    output logic [$bits(t_mempipe_arb)-1:0]            pipe_req_pkt_mm5,
    output logic [$bits(t_mempipe_action)-1:0]         pipe_action_mm5
);

    localparam int unsigned LIW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
    localparam int unsigned SIW = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;

    t_nuke_pkt       nuke;
    logic [NUM_LD-1:0] ld_elig, ld_gnt_raw;
    logic [NUM_ST-1:0] st_elig, st_gnt_raw;
    logic [LIW-1:0]  ld_ptr, ld_idx;
    logic [SIW-1:0]  st_ptr, st_idx;
    logic            st_win, ld_win;
    t_mempipe_arb    pkt_mm0;
    t_mempipe_action act;

    logic            stage_v   [1:NUM_MEMPIPE_STAGES];
    t_mempipe_arb    stage_pkt [1:NUM_MEMPIPE_STAGES];

    assign nuke = t_nuke_pkt'(nuke_rb1);

    // Nukeable requesters sit out while a flush is active; reset masks everything.
    always_comb begin
        t_mempipe_arb p;
        ld_elig = '0;
        st_elig = '0;
        for (int unsigned i = 0; i < NUM_LD; i++) begin
            p = t_mempipe_arb'(ld_req_pkt_mm0[i]);
            ld_elig[i] = ld_req_mm0[i] & ~(nuke.valid & p.nukeable) & ~reset;
        end
        for (int unsigned i = 0; i < NUM_ST; i++) begin
            p = t_mempipe_arb'(st_req_pkt_mm0[i]);
            st_elig[i] = st_req_mm0[i] & ~(nuke.valid & p.nukeable) & ~reset;
        end
    end

    rr_arb #(.N(NUM_LD)) u_ld_arb (
        .req(ld_elig), .ptr(ld_ptr), .gnt(ld_gnt_raw), .gnt_idx(ld_idx)
    );

    rr_arb #(.N(NUM_ST)) u_st_arb (
        .req(st_elig), .ptr(st_ptr), .gnt(st_gnt_raw), .gnt_idx(st_idx)
    );

    assign st_win     = |st_elig;
    assign st_gnt_mm0 = st_gnt_raw;
    assign ld_gnt_mm0 = st_win ? '0 : ld_gnt_raw;
    assign ld_win     = |ld_gnt_mm0;

    always_comb begin
        if (st_win) begin
            pkt_mm0          = t_mempipe_arb'(st_req_pkt_mm0[st_idx]);
            pkt_mm0.arb_type = MEM_STORE;
            pkt_mm0.id       = ID_W'(st_idx);
        end else begin
            pkt_mm0          = t_mempipe_arb'(ld_req_pkt_mm0[ld_idx]);
            pkt_mm0.arb_type = MEM_LOAD;
            pkt_mm0.id       = ID_W'(ld_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k <= NUM_MEMPIPE_STAGES; k++) begin
                stage_v[k]   <= 1'b0;
                stage_pkt[k] <= '0;
            end
            ld_ptr <= '0;
            st_ptr <= '0;
        end else begin
            stage_v[1]   <= st_win | ld_win;
            stage_pkt[1] <= pkt_mm0;
            for (int unsigned k = 2; k <= NUM_MEMPIPE_STAGES; k++) begin
                stage_v[k]   <= stage_v[k-1] & ~(nuke.valid & stage_pkt[k-1].nukeable);
                stage_pkt[k] <= stage_pkt[k-1];
            end
            if (st_win)
                st_ptr <= SIW'(rr_next(32'(st_idx), NUM_ST));
            else if (ld_win)
                ld_ptr <= LIW'(rr_next(32'(ld_idx), NUM_LD));
        end
    end

    assign dc_req_mm1  = stage_v[1];
    assign dc_addr_mm1 = stage_pkt[1].addr;

    always_comb begin
        t_mempipe_arb p5;
        logic         blocked;
        p5             = stage_pkt[NUM_MEMPIPE_STAGES];
        pipe_valid_mm5 = stage_v[NUM_MEMPIPE_STAGES] & ~(nuke.valid & p5.nukeable);
        blocked        = |(p5.older_stq_ents[NUM_ST-1:0] & stq_e_valid);
        act            = '0;
        if (pipe_valid_mm5) begin
            act.complete = (p5.arb_type == MEM_LOAD) ? (dc_hit_mm5 & ~blocked) : dc_hit_mm5;
            act.recycle  = ~act.complete;
        end
    end

    assign pipe_req_pkt_mm5 = stage_pkt[NUM_MEMPIPE_STAGES];
    assign pipe_action_mm5  = act;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0({st_gnt_mm0, ld_gnt_mm0}));
    a_gnt_req: assert property (@(posedge clk) disable iff (reset)
        ((ld_gnt_mm0 & ~ld_req_mm0) == '0) && ((st_gnt_mm0 & ~st_req_mm0) == '0));

endmodule

// File: tb/tb_mem_pipe_ctl.sv
// Self-checking bench for mem_pipe_ctl: directed scenarios plus random traffic,
// compared each cycle against an op-list reference model.
module tb_mem_pipe_ctl;
    import mem_pipe_ctl_pkg::*;

    localparam int NL    = 8;
    localparam int NS    = 8;
    localparam int PKT_W = $bits(t_mempipe_arb);

    logic                       clk = 1'b0;
    logic                       reset;
    logic [0:0]                 nuke_rb1;
    logic [NL-1:0]              ld_req_mm0;
    logic [NL-1:0][PKT_W-1:0]   ld_req_pkt_mm0;
    logic [NL-1:0]              ld_gnt_mm0;
    logic [NS-1:0]              st_req_mm0;
    logic [NS-1:0][PKT_W-1:0]   st_req_pkt_mm0;
    logic [NS-1:0]              st_gnt_mm0;
    logic [NS-1:0]              stq_e_valid;
    logic                       dc_req_mm1;
    logic [31:0]                dc_addr_mm1;
    logic                       dc_hit_mm5;
    logic                       pipe_valid_mm5;
    logic [PKT_W-1:0]           pipe_req_pkt_mm5;
    logic [3:0]                 pipe_action_mm5;

    always #5 clk = ~clk;

    mem_pipe_ctl #(.NUM_LD(NL), .NUM_ST(NS)) dut (
        .clk(clk), .reset(reset), .nuke_rb1(nuke_rb1),
        .ld_req_mm0(ld_req_mm0), .ld_req_pkt_mm0(ld_req_pkt_mm0), .ld_gnt_mm0(ld_gnt_mm0),
        .st_req_mm0(st_req_mm0), .st_req_pkt_mm0(st_req_pkt_mm0), .st_gnt_mm0(st_gnt_mm0),
        .stq_e_valid(stq_e_valid), .dc_req_mm1(dc_req_mm1), .dc_addr_mm1(dc_addr_mm1),
        .dc_hit_mm5(dc_hit_mm5), .pipe_valid_mm5(pipe_valid_mm5),
        .pipe_req_pkt_mm5(pipe_req_pkt_mm5), .pipe_action_mm5(pipe_action_mm5)
    );

    // Every in-flight op is remembered with the cycle it was granted; its stage is cyc - born.
    typedef struct {
        t_mempipe_arb pkt;
        int           born;
    } op_t;

    op_t q[$];
    int  cyc, ld_ptr, st_ptr;
    int  n_pass, n_chk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic t_mempipe_arb mk(input t_mem_arb_type t, input int id, input logic [31:0] a,
                                        input logic nk, input logic [7:0] older);
        t_mempipe_arb p;
        p.arb_type       = t;
        p.id             = 4'(id);
        p.addr           = a;
        p.nukeable       = nk;
        p.older_stq_ents = older;
        return p;
    endfunction

    task automatic set_ld(input int i, input logic [31:0] a, input logic nk, input logic [7:0] older);
        ld_req_pkt_mm0[i] = mk(MEM_LOAD, i, a, nk, older);
    endtask

    task automatic set_st(input int i, input logic [31:0] a, input logic nk);
        st_req_pkt_mm0[i] = mk(MEM_STORE, i, a, nk, 8'h00);
    endtask

    function automatic int pick(input logic [15:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++)
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        return -1;
    endfunction

    function automatic int find(input int b);
        for (int i = 0; i < q.size(); i++)
            if (q[i].born == b) return i;
        return -1;
    endfunction

    task automatic step();
        logic [15:0]     le, se;
        int              li, si, k1, k5;
        logic            ev, blocked;
        t_mempipe_action ea;
        t_mempipe_arb    p;
        op_t             nq[$];
        op_t             o;

        @(negedge clk);
        le = '0;
        se = '0;
        for (int i = 0; i < NL; i++) begin
            p = t_mempipe_arb'(ld_req_pkt_mm0[i]);
            le[i] = ld_req_mm0[i] && !(nuke_rb1[0] && p.nukeable);
        end
        for (int i = 0; i < NS; i++) begin
            p = t_mempipe_arb'(st_req_pkt_mm0[i]);
            se[i] = st_req_mm0[i] && !(nuke_rb1[0] && p.nukeable);
        end
        si = pick(se, st_ptr, NS);
        li = (si < 0) ? pick(le, ld_ptr, NL) : -1;
        chk("st_gnt", 64'(st_gnt_mm0), (si >= 0) ? 64'(1) << si : 64'(0));
        chk("ld_gnt", 64'(ld_gnt_mm0), (li >= 0) ? 64'(1) << li : 64'(0));

        k1 = find(cyc - 1);
        chk("dc_req", 64'(dc_req_mm1), 64'(k1 >= 0));
        if (k1 >= 0) chk("dc_addr", 64'(dc_addr_mm1), 64'(q[k1].pkt.addr));

        k5 = find(cyc - 5);
        ev = (k5 >= 0) && !(nuke_rb1[0] && q[k5].pkt.nukeable);
        ea = '0;
        if (ev) begin
            blocked = |(q[k5].pkt.older_stq_ents & stq_e_valid);
            if (q[k5].pkt.arb_type == MEM_LOAD) ea.complete = dc_hit_mm5 && !blocked;
            else                                ea.complete = dc_hit_mm5;
            ea.recycle = !ea.complete;
        end
        chk("pipe_valid", 64'(pipe_valid_mm5), 64'(ev));
        chk("action", 64'(pipe_action_mm5), 64'(ea));
        if (ev) chk("pkt5", 64'(pipe_req_pkt_mm5), 64'(q[k5].pkt));

        // Retire the mm5 op and anything flushed this cycle.
        foreach (q[i])
            if (q[i].born > cyc - 5 && !(nuke_rb1[0] && q[i].pkt.nukeable)) nq.push_back(q[i]);
        q = nq;
        if (si >= 0) begin
            o.pkt = t_mempipe_arb'(st_req_pkt_mm0[si]);
            o.pkt.arb_type = MEM_STORE;
            o.pkt.id = 4'(si);
            o.born = cyc;
            q.push_back(o);
            st_ptr = (si + 1) % NS;
        end else if (li >= 0) begin
            o.pkt = t_mempipe_arb'(ld_req_pkt_mm0[li]);
            o.pkt.arb_type = MEM_LOAD;
            o.pkt.id = 4'(li);
            o.born = cyc;
            q.push_back(o);
            ld_ptr = (li + 1) % NL;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0; n_chk = 0; cyc = 0; ld_ptr = 0; st_ptr = 0;
        reset = 1'b1; nuke_rb1 = '0; dc_hit_mm5 = 1'b1; stq_e_valid = '0;
        ld_req_mm0 = '1; st_req_mm0 = '0;
        for (int i = 0; i < NL; i++) set_ld(i, 32'h0, 1'b0, 8'h00);
        for (int i = 0; i < NS; i++) set_st(i, 32'h0, 1'b0);
        #3;
        chk("rst_ld_gnt", 64'(ld_gnt_mm0), 64'(0));
        chk("rst_dc_req", 64'(dc_req_mm1), 64'(0));
        chk("rst_pipe_valid", 64'(pipe_valid_mm5), 64'(0));
        chk("rst_action", 64'(pipe_action_mm5), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; ld_req_mm0 = '0;

        // Single load, id 3, hit, no older stores.
        set_ld(3, 32'h1000, 1'b0, 8'h00);
        ld_req_mm0 = 8'b0000_1000;
        step();
        ld_req_mm0 = '0;
        repeat (6) step();

        // Round robin over loads 0, 2, 5.
        set_ld(0, 32'h100, 1'b0, 8'h00);
        set_ld(2, 32'h200, 1'b0, 8'h00);
        set_ld(5, 32'h500, 1'b0, 8'h00);
        ld_req_mm0 = 8'b0010_0101;
        repeat (6) step();
        ld_req_mm0 = '0;
        repeat (5) step();

        // Store beats load in the same cycle.
        set_ld(1, 32'h110, 1'b0, 8'h00);
        set_st(4, 32'h440, 1'b0);
        ld_req_mm0 = 8'b0000_0010; st_req_mm0 = 8'b0001_0000;
        step();
        st_req_mm0 = '0;
        step();
        ld_req_mm0 = '0;
        repeat (5) step();

        // Load blocked by an older live store, then unblocked before mm5.
        set_ld(6, 32'h2000, 1'b0, 8'b0000_0100);
        stq_e_valid = 8'b0000_0100;
        ld_req_mm0 = 8'b0100_0000;
        step();
        ld_req_mm0 = '0;
        repeat (5) step();
        ld_req_mm0 = 8'b0100_0000;
        step();
        ld_req_mm0 = '0;
        step();
        stq_e_valid = '0;
        repeat (4) step();

        // Nuke with nukeable loads at mm5/mm3/mm2 and a non-nukeable store at mm4.
        set_ld(1, 32'h3000, 1'b1, 8'h00);
        ld_req_mm0 = 8'b0000_0010;
        step();
        ld_req_mm0 = '0;
        set_st(2, 32'h4000, 1'b0);
        st_req_mm0 = 8'b0000_0100;
        step();
        st_req_mm0 = '0;
        set_ld(3, 32'h3300, 1'b1, 8'h00);
        ld_req_mm0 = 8'b0000_1000;
        step();
        set_ld(5, 32'h3500, 1'b1, 8'h00);
        ld_req_mm0 = 8'b0010_0000;
        step();
        ld_req_mm0 = '0;
        step();
        nuke_rb1 = 1'b1;
        step();
        nuke_rb1 = 1'b0;
        repeat (5) step();

        // Random traffic.
        repeat (400) begin
            for (int i = 0; i < NL; i++)
                set_ld(i, $urandom, 1'($urandom_range(0, 1)), 8'($urandom));
            for (int i = 0; i < NS; i++)
                set_st(i, $urandom, 1'($urandom_range(0, 1)));
            ld_req_mm0  = 8'($urandom);
            st_req_mm0  = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            nuke_rb1    = 1'($urandom_range(0, 7) == 0);
            stq_e_valid = 8'($urandom);
            dc_hit_mm5  = 1'($urandom_range(0, 1));
            step();
        end

        // Reset with ops in flight.
        nuke_rb1 = '0; st_req_mm0 = '0; ld_req_mm0 = 8'hFF;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_pipe_valid", 64'(pipe_valid_mm5), 64'(0));
        chk("mid_rst_dc_req", 64'(dc_req_mm1), 64'(0));
        chk("mid_rst_ld_gnt", 64'(ld_gnt_mm0), 64'(0));
        chk("mid_rst_action", 64'(pipe_action_mm5), 64'(0));
        q.delete();
        ld_ptr = 0; st_ptr = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        ld_req_mm0 = 8'b0000_1111;
        step();
        ld_req_mm0 = '0;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
